// File: rtl/wb_bus_router_if.sv
// ---------------------------------------------------------------------------
// wb_bus_router_if
// Bundles the CPU strobe bus and the N-slave Wishbone bus handled by
// wb_bus_router.
//   CPU side : cs, we, addr, din  -> router ; dout, rdy, err <- router
//   WB side  : wb_stbo, wb_rwo, wb_adro, wb_dato <- router
//              wb_acki, wb_dati                  -> router
// Modports:
//   slave  - the router's view (it serves the CPU and drives the slaves)
//   master - the environment's view (CPU plus the Wishbone slaves)
// ---------------------------------------------------------------------------
interface wb_bus_router_if #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8
);
  logic                         cs;
  logic                         we;
  logic [ADDR_W-1:0]            addr;
  logic [DATA_W-1:0]            din;
  logic [DATA_W-1:0]            dout;
  logic                         rdy;
  logic                         err;
  logic [NUM_SLAVES-1:0]        wb_stbo;
  logic                         wb_rwo;
  logic [ADDR_W-1:0]            wb_adro;
  logic [DATA_W-1:0]            wb_dato;
  logic [NUM_SLAVES-1:0]        wb_acki;
  logic [NUM_SLAVES*DATA_W-1:0] wb_dati;

  modport slave (
    input  cs, we, addr, din, wb_acki, wb_dati,
    output dout, rdy, err, wb_stbo, wb_rwo, wb_adro, wb_dato
  );

  modport master (
    output cs, we, addr, din, wb_acki, wb_dati,
    input  dout, rdy, err, wb_stbo, wb_rwo, wb_adro, wb_dato
  );
endinterface

// File: rtl/wb_bus_router.sv
// ---------------------------------------------------------------------------
// wb_bus_router
// CPU-to-Wishbone bridge and N-slave router. A level cs from the CPU starts
// one Wishbone transfer to the slave whose 4-bit bank ID matches the top
// nibble of addr (lowest index wins). Read data is taken from the selected
// slave only. Unmapped banks complete immediately with an error; when the
// timeout is built in, a slave that never acks also completes with an error.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - wb_bus_router_if.slave (CPU strobe bus + Wishbone master bus)
//
// Build option:
//   WB_BUS_ROUTER_TIMEOUT_EN - when defined, BUSY gives up after TIMEOUT
//   cycles without an ack. When undefined there is no counter, BUSY waits
//   forever and TIMEOUT has no effect.
// ---------------------------------------------------------------------------
module wb_bus_router #(
  parameter int                          NUM_SLAVES  = 3,
  parameter int                          ADDR_W      = 8,
  parameter int                          DATA_W      = 8,
  parameter logic [4*NUM_SLAVES-1:0]     SLAVE_BANKS = {4'h1, 4'h2, 4'h0},
  parameter int                          TIMEOUT     = 255,
  parameter logic [DATA_W-1:0]           ERR_DATA    = {DATA_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  wb_bus_router_if.slave   bus
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || ADDR_W < 4 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("wb_bus_router: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] stbo_q,  stbo_d;
  logic                  rwo_q,   rwo_d;
  logic [ADDR_W-1:0]     adro_q,  adro_d;
  logic [DATA_W-1:0]     dato_q,  dato_d;
  logic [DATA_W-1:0]     dout_q,  dout_d;
  logic                  rdy_q,   rdy_d;
  logic                  err_q,   err_d;

`ifdef WB_BUS_ROUTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]           cnt_q,   cnt_d;
`endif

  // Bank decode of the live CPU address. Scanning from the top index down
  // lets the lowest matching slave overwrite any higher match.
  logic                  hit;
  logic [NUM_SLAVES-1:0] hit_oh;

  always_comb begin
    hit    = 1'b0;
    hit_oh = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (bus.addr[ADDR_W-1 -: 4] == SLAVE_BANKS[4*i +: 4]) begin
        hit       = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Only the selected slave's ack and data matter; the strobe register is
  // one-hot, so it doubles as the mux select.
  logic              ack;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    ack     = |(bus.wb_acki & stbo_q);
    rd_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (stbo_q[i]) rd_data = bus.wb_dati[DATA_W*i +: DATA_W];
    end
  end

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    stbo_d  = stbo_q;
    rwo_d   = rwo_q;
    adro_d  = adro_q;
    dato_d  = dato_q;
    dout_d  = dout_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.cs) begin
          rwo_d  = bus.we;
          adro_d = bus.addr;
          dato_d = bus.din;
          if (hit) begin
            stbo_d  = hit_oh;
            state_d = ST_BUSY;
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            // Unmapped bank: finish at once, never touch the bus.
            rdy_d   = 1'b1;
            err_d   = 1'b1;
            dout_d  = ERR_DATA;
            state_d = ST_HOLD;
          end
        end
      end

      ST_BUSY: begin
        // An ack wins over a timeout expiring in the same cycle.
        if (ack) begin
          stbo_d  = '0;
          dout_d  = rwo_q ? '0 : rd_data;
          rdy_d   = 1'b1;
          err_d   = 1'b0;
          state_d = ST_HOLD;
        end
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          stbo_d  = '0;
          dout_d  = ERR_DATA;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end

      ST_HOLD: begin
        // dout keeps the last result after the handshake closes.
        if (!bus.cs) begin
          rdy_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        stbo_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      stbo_q  <= '0;
      rwo_q   <= 1'b0;
      adro_q  <= '0;
      dato_q  <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stbo_q  <= stbo_d;
      rwo_q   <= rwo_d;
      adro_q  <= adro_d;
      dato_q  <= dato_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.wb_stbo = stbo_q;
  assign bus.wb_rwo  = rwo_q;
  assign bus.wb_adro = adro_q;
  assign bus.wb_dato = dato_q;
  assign bus.dout    = dout_q;
  assign bus.rdy     = rdy_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_wb_bus_router.sv
// ---------------------------------------------------------------------------
// tb_wb_bus_router
// Directed bench for wb_bus_router with default parameters
// (slave 0 = bank 0, slave 1 = bank 2, slave 2 = bank 1).
// Expected completions go into a scoreboard queue when a transfer is
// launched and are popped when rdy rises. Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_wb_bus_router;

  logic clk;
  logic rst;

  wb_bus_router_if #(.NUM_SLAVES(3), .ADDR_W(8), .DATA_W(8)) bus ();

  wb_bus_router #(
    .NUM_SLAVES (3),
    .ADDR_W     (8),
    .DATA_W     (8),
    .SLAVE_BANKS({4'h1, 4'h2, 4'h0}),
    .TIMEOUT    (255),
    .ERR_DATA   (8'hFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic e);
    exp_t x;
    x.dout = d;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  // Compare the current completion against the oldest queued expectation.
  task automatic pop_check(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      check({tag, "/sb_underflow"}, 32'd1, 32'd0);
    end else begin
      x = sb_q.pop_front();
      check({tag, "/dout"}, bus.dout, x.dout);
      check({tag, "/err"},  bus.err,  x.err);
    end
  endtask

  task automatic wait_rdy(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.rdy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/rdy"}, bus.rdy, 1'b1);
  endtask

  task automatic release_cs(input string tag, input logic [7:0] held);
    bus.cs = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "/rdy_clr"},  bus.rdy,  1'b0);
    check({tag, "/err_clr"},  bus.err,  1'b0);
    check({tag, "/dout_hold"}, bus.dout, held);
  endtask

  // One complete transfer. slv < 0 means the bank is unmapped.
  task automatic xfer(input string tag, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input int slv, input int ack_dly,
                      input logic [7:0] rdata);
    logic [2:0] exp_stb;
    logic [7:0] exp_dout;
    exp_stb  = (slv >= 0) ? 3'(1 << slv) : 3'b000;
    exp_dout = (slv < 0) ? 8'hFF : (w ? 8'h00 : rdata);
    push_exp(exp_dout, slv < 0);
    bus.cs   = 1'b1;
    bus.we   = w;
    bus.addr = a;
    bus.din  = d;
    @(negedge clk);
    check({tag, "/stb"}, bus.wb_stbo, exp_stb);
    if (slv >= 0) begin
      check({tag, "/adro"}, bus.wb_adro, a);
      check({tag, "/dato"}, bus.wb_dato, d);
      check({tag, "/rwo"},  bus.wb_rwo,  w);
      repeat (ack_dly) @(negedge clk);
      check({tag, "/stb_hold"}, bus.wb_stbo, exp_stb);
      check({tag, "/no_rdy_yet"}, bus.rdy, 1'b0);
      bus.wb_dati[8*slv +: 8] = rdata;
      bus.wb_acki = exp_stb;
      @(negedge clk);
      bus.wb_acki = '0;
    end
    wait_rdy(tag, 16);
    pop_check(tag);
    check({tag, "/stb_off"}, bus.wb_stbo, 3'b000);
    release_cs(tag, exp_dout);
  endtask

  initial begin
    int n;
    rst         = 1'b0;
    bus.cs      = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = '0;
    bus.din     = '0;
    bus.wb_acki = '0;
    bus.wb_dati = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst/stb",  bus.wb_stbo, 3'b000);
    check("rst/rwo",  bus.wb_rwo,  1'b0);
    check("rst/adro", bus.wb_adro, 8'h00);
    check("rst/dato", bus.wb_dato, 8'h00);
    check("rst/dout", bus.dout,    8'h00);
    check("rst/rdy",  bus.rdy,     1'b0);
    check("rst/err",  bus.err,     1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("idle/rdy", bus.rdy, 1'b0);

    // 1. Read slave 0
    xfer("rd_s0", 1'b0, 8'h05, 8'h00, 0, 2, 8'hA5);

    // 2. Write slave 2 (bank 1)
    xfer("wr_s2", 1'b1, 8'h1C, 8'h3C, 2, 1, 8'h5E);

    // 3. Unmapped bank 7: no strobe, immediate error
    xfer("unmap", 1'b0, 8'h70, 8'h00, -1, 0, 8'h00);

    // Read slave 1 (bank 2) with a different data pattern
    xfer("rd_s1", 1'b0, 8'h2F, 8'h00, 1, 0, 8'hC3);

    // 5. Ack from a non-selected slave is ignored
    push_exp(8'h22, 1'b0);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h2A;
    @(negedge clk);
    check("wrong_ack/stb", bus.wb_stbo, 3'b010);
    bus.wb_dati = {8'h00, 8'h00, 8'h11};
    bus.wb_acki = 3'b001;
    @(negedge clk);
    check("wrong_ack/ignored_rdy", bus.rdy, 1'b0);
    check("wrong_ack/ignored_stb", bus.wb_stbo, 3'b010);
    bus.wb_dati = {8'h00, 8'h22, 8'h11};
    bus.wb_acki = 3'b010;
    @(negedge clk);
    bus.wb_acki = '0;
    wait_rdy("wrong_ack", 16);
    pop_check("wrong_ack");
    release_cs("wrong_ack", 8'h22);

    // 4. Hung slave 1
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h20;
`ifdef WB_BUS_ROUTER_TIMEOUT_EN
    push_exp(8'hFF, 1'b1);
    n = 0;
    for (int c = 0; c < 1000 && bus.rdy !== 1'b1; c++) begin
      @(negedge clk);
      if (bus.rdy !== 1'b1 && bus.wb_stbo == 3'b010) n++;
    end
    check("hung/busy_cycles", n, 255);
    check("hung/rdy", bus.rdy, 1'b1);
    check("hung/stb_off", bus.wb_stbo, 3'b000);
    pop_check("hung");
    release_cs("hung", 8'hFF);

    // Ack arriving in the expiry cycle completes normally
    push_exp(8'h77, 1'b0);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h21;
    n = 0;
    while (n < 255 && bus.rdy !== 1'b1) begin
      @(negedge clk);
      if (bus.wb_stbo == 3'b010) n++;
    end
    check("tmo_race/stb_cycles", n, 255);
    bus.wb_dati = {8'h00, 8'h77, 8'h00};
    bus.wb_acki = 3'b010;
    @(negedge clk);
    bus.wb_acki = '0;
    check("tmo_race/rdy", bus.rdy, 1'b1);
    pop_check("tmo_race");
    release_cs("tmo_race", 8'h77);
`else
    push_exp(8'h99, 1'b0);
    repeat (1000) @(negedge clk);
    check("hung/stb_still", bus.wb_stbo, 3'b010);
    check("hung/no_rdy", bus.rdy, 1'b0);
    bus.wb_dati = {8'h00, 8'h99, 8'h00};
    bus.wb_acki = 3'b010;
    @(negedge clk);
    bus.wb_acki = '0;
    wait_rdy("hung", 16);
    pop_check("hung");
    release_cs("hung", 8'h99);
`endif

    // 6. Async reset during BUSY
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 8'h05;
    @(negedge clk);
    check("arst/stb_before", bus.wb_stbo, 3'b001);
    #1 rst = 1'b0;
    #1;
    check("arst/stb", bus.wb_stbo, 3'b000);
    check("arst/rdy", bus.rdy, 1'b0);
    bus.cs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst/idle_stb", bus.wb_stbo, 3'b000);
    xfer("post_rst", 1'b0, 8'h0B, 8'h00, 0, 1, 8'h5A);

    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global guard so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
